// File: rtl/mbist_pkg.sv
// Shared types and March C- element table for the memory BIST controller.
// Tables are indexed by element number (bit i describes element Mi).
package mbist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned NumElem = 6;

    // M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 dn(r0,w1); M4 dn(r1,w0); M5 dn(r0)
    localparam logic [7:0] ElemDown   = 8'b0011_1000;
    localparam logic [7:0] ElemTwoOps = 8'b0001_1110;
    localparam logic [7:0] ElemWr0    = 8'b0000_0001;
    localparam logic [7:0] ElemWr1    = 8'b0001_1110;
    localparam logic [7:0] ElemPol0   = 8'b0001_0100;
    localparam logic [7:0] ElemPol1   = 8'b0000_1010;

    localparam logic [1:0] BgSolid   = 2'b00;
    localparam logic [1:0] BgColChk  = 2'b01;
    localparam logic [1:0] BgAddrChk = 2'b10;
    localparam logic [1:0] BgRsvd    = 2'b11;

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Memory-side bus between the BIST controller (master) and the memory under test (slave).
interface mbist_march_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) ();
    logic                  write_read;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output write_read,
        output address,
        output wdata,
        input  rdata
    );

    modport slave (
        input  write_read,
        input  address,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/mbist_cmp.sv
// Two-stage read-compare pipeline with first-fail capture and a saturating error counter.
module mbist_cmp #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_rd_vld,
    input  logic [DATA_WIDTH-1:0] i_rd_exp,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic [2:0]            i_rd_elem,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_fail,
    output logic [ADDR_WIDTH-1:0] o_fail_addr,
    output logic [DATA_WIDTH-1:0] o_fail_data,
    output logic [2:0]            o_fail_elem,
    output logic [7:0]            o_err_count
);
    logic                  r_s1_vld, r_s2_vld;
    logic [DATA_WIDTH-1:0] r_s1_exp, r_s2_exp;
    logic [ADDR_WIDTH-1:0] r_s1_addr, r_s2_addr;
    logic [2:0]            r_s1_elem, r_s2_elem;
    logic                  r_fail;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [DATA_WIDTH-1:0] r_fail_data;
    logic [2:0]            r_fail_elem;
    logic [7:0]            r_err;
    logic                  w_miss;

    // rdata belongs to the read issued two cycles ago, i.e. the op now in stage 2
    assign w_miss = r_s2_vld && (i_rdata != r_s2_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld    <= 1'b0;
            r_s1_exp    <= '0;
            r_s1_addr   <= '0;
            r_s1_elem   <= '0;
            r_s2_vld    <= 1'b0;
            r_s2_exp    <= '0;
            r_s2_addr   <= '0;
            r_s2_elem   <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_fail_elem <= '0;
            r_err       <= '0;
        end else begin
            r_s1_vld  <= i_rd_vld;
            r_s1_exp  <= i_rd_exp;
            r_s1_addr <= i_rd_addr;
            r_s1_elem <= i_rd_elem;
            r_s2_vld  <= r_s1_vld;
            r_s2_exp  <= r_s1_exp;
            r_s2_addr <= r_s1_addr;
            r_s2_elem <= r_s1_elem;
            if (i_clear) begin
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_data <= '0;
                r_fail_elem <= '0;
                r_err       <= '0;
            end else if (w_miss) begin
                if (!r_fail) begin
                    r_fail_addr <= r_s2_addr;
                    r_fail_data <= i_rdata;
                    r_fail_elem <= r_s2_elem;
                end
                r_fail <= 1'b1;
                if (r_err != 8'hFF) begin
                    r_err <= r_err + 8'd1;
                end
            end
        end
    end

    assign o_fail      = r_fail;
    assign o_fail_addr = r_fail_addr;
    assign o_fail_data = r_fail_data;
    assign o_fail_elem = r_fail_elem;
    assign o_err_count = r_err;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: walks six March elements over 0..MAX_ADDR, one memory
// op per cycle, and hands every read to mbist_cmp for checking two cycles later.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAX_ADDR   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            bg_sel,
    mbist_march_ctrl_if.master    mem,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [2:0]            fail_elem,
    output logic [7:0]            err_count
);
    localparam logic [ADDR_WIDTH-1:0]   LastAddr = ADDR_WIDTH'(MAX_ADDR);
    localparam logic [ADDR_WIDTH-1:0]   AddrOne  = ADDR_WIDTH'(1);
    localparam logic [2:0]              LastElem = 3'(NumElem - 1);
    localparam logic [2*DATA_WIDTH-1:0] Rep55    = {DATA_WIDTH{2'b01}};
    localparam logic [DATA_WIDTH-1:0]   Pat55    = Rep55[DATA_WIDTH-1:0];

    state_e                r_state, w_state_nxt;
    logic [2:0]            r_elem, w_elem_nxt, w_elem_inc;
    logic                  r_slot, w_slot_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic                  r_drain, w_drain_nxt;
    logic [1:0]            r_bg, w_bg_nxt;
    logic                  w_run, w_down, w_last_slot, w_last_addr, w_last_elem;
    logic                  w_op_wr, w_op_pol, w_nxt_wr, w_nxt_pol;
    logic [DATA_WIDTH-1:0] w_rd_exp;

    function automatic logic [DATA_WIDTH-1:0] bg_pattern(input logic [1:0] bg,
                                                         input logic a_lsb);
        logic [DATA_WIDTH-1:0] p;
        p = '0;
        if (bg == BgColChk) begin
            p = Pat55;
        end else if (bg == BgAddrChk) begin
            p = a_lsb ? ~Pat55 : Pat55;
        end
        return p;
    endfunction

    assign w_run       = (r_state == StRun);
    assign w_elem_inc  = r_elem + 3'd1;
    assign w_down      = ElemDown[r_elem];
    assign w_last_slot = !ElemTwoOps[r_elem] || r_slot;
    assign w_last_addr = w_down ? (r_addr == '0) : (r_addr == LastAddr);
    assign w_last_elem = (r_elem == LastElem);
    assign w_op_wr     = r_slot ? ElemWr1[r_elem] : ElemWr0[r_elem];
    assign w_op_pol    = r_slot ? ElemPol1[r_elem] : ElemPol0[r_elem];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_elem  <= '0;
            r_slot  <= 1'b0;
            r_addr  <= '0;
            r_drain <= 1'b0;
            r_bg    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_elem  <= w_elem_nxt;
            r_slot  <= w_slot_nxt;
            r_addr  <= w_addr_nxt;
            r_drain <= w_drain_nxt;
            r_bg    <= w_bg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_elem_nxt  = r_elem;
        w_slot_nxt  = r_slot;
        w_addr_nxt  = r_addr;
        w_drain_nxt = r_drain;
        w_bg_nxt    = r_bg;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt = StRun;
                    w_elem_nxt  = '0;
                    w_slot_nxt  = 1'b0;
                    w_addr_nxt  = '0;
                    w_bg_nxt    = bg_sel;
                end
            end
            StRun: begin
                if (!w_last_slot) begin
                    w_slot_nxt = 1'b1;
                end else begin
                    w_slot_nxt = 1'b0;
                    if (!w_last_addr) begin
                        w_addr_nxt = w_down ? r_addr - AddrOne : r_addr + AddrOne;
                    end else if (!w_last_elem) begin
                        w_elem_nxt = w_elem_inc;
                        w_addr_nxt = ElemDown[w_elem_inc] ? LastAddr : '0;
                    end else begin
                        w_state_nxt = StDrain;
                        w_elem_nxt  = '0;
                        w_addr_nxt  = '0;
                        w_drain_nxt = 1'b0;
                    end
                end
            end
            StDrain: begin
                w_drain_nxt = 1'b1;
                if (r_drain) begin
                    w_state_nxt = StDone;
                    w_drain_nxt = 1'b0;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // The memory samples wdata a cycle early, so wdata is derived from the op issued next
    // cycle; this includes the start-accept cycle in IDLE, which precedes the first write.
    assign w_nxt_wr  = (w_state_nxt == StRun) && !rst &&
                       (w_slot_nxt ? ElemWr1[w_elem_nxt] : ElemWr0[w_elem_nxt]);
    assign w_nxt_pol = w_slot_nxt ? ElemPol1[w_elem_nxt] : ElemPol0[w_elem_nxt];

    assign mem.write_read = w_run && w_op_wr;
    assign mem.address    = w_run ? r_addr : '0;
    assign mem.wdata      = w_nxt_wr ?
                            (bg_pattern(w_bg_nxt, w_addr_nxt[0]) ^ {DATA_WIDTH{w_nxt_pol}}) : '0;

    assign busy     = w_run || (r_state == StDrain);
    assign done     = (r_state == StDone);
    assign w_rd_exp = bg_pattern(r_bg, r_addr[0]) ^ {DATA_WIDTH{w_op_pol}};

    mbist_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cmp (
        .clk         (clk),
        .rst         (rst),
        .i_clear     ((r_state == StIdle) && start),
        .i_rd_vld    (w_run && !w_op_wr),
        .i_rd_exp    (w_rd_exp),
        .i_rd_addr   (r_addr),
        .i_rd_elem   (r_elem),
        .i_rdata     (mem.rdata),
        .o_fail      (fail),
        .o_fail_addr (fail_addr),
        .o_fail_data (fail_data),
        .o_fail_elem (fail_elem),
        .o_err_count (err_count)
    );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: table of background/fault scenarios plus reset-abort and
// ignored-restart sequences, with a per-cycle op-sequence monitor against a March C- model.
`timescale 1ns/1ps
module tb_mbist_march_ctrl;
    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int MAXA = 15;
    localparam int N    = MAXA + 1;
    localparam int RUNC = 10 * N;
    localparam int FNone  = 0;
    localparam int FStuck = 1;
    localparam int FCoup  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    bg_sel = 2'b00;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [2:0]    fail_elem;
    logic [7:0]    err_count;

    int n_tests = 0;
    int n_fail  = 0;

    mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_if ();

    mbist_march_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_ADDR   (MAXA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bg_sel    (bg_sel),
        .mem       (mem_if),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .fail_elem (fail_elem),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Memory model: write data is the wdata seen one cycle earlier; reads return 2 cycles later.
    // Stuck fault: addr 5 bit 3 stuck at 0. Coupling fault: writes to 7 or 9 also land in 8.
    int            fault_mode = FNone;
    logic [DW-1:0] mem_arr [0:255];
    logic [DW-1:0] wd_prev, rd_s1;

    always @(posedge clk) begin
        wd_prev <= mem_if.wdata;
        rd_s1   <= mem_arr[mem_if.address];
        mem_if.rdata <= rd_s1;
        if (mem_if.write_read) begin
            if (fault_mode == FStuck && mem_if.address == 8'd5) begin
                mem_arr[mem_if.address] <= wd_prev & 8'hF7;
            end else begin
                mem_arr[mem_if.address] <= wd_prev;
            end
            if (fault_mode == FCoup && (mem_if.address == 8'd7 || mem_if.address == 8'd9)) begin
                mem_arr[8] <= wd_prev;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [1:0] bg, input int a);
        if (bg == 2'b01) return 8'h55;
        if (bg == 2'b10) return (a % 2 == 1) ? 8'hAA : 8'h55;
        return 8'h00;
    endfunction

    // Op issued in RUN cycle k of March C- over N addresses.
    function automatic void exp_op(input int k, output logic wr, output int a, output logic pol);
        int j;
        if (k < N) begin
            wr = 1'b1; a = k; pol = 1'b0;
        end else if (k < 3 * N) begin
            j = k - N;     a = j / 2;            wr = j[0]; pol = j[0];
        end else if (k < 5 * N) begin
            j = k - 3 * N; a = j / 2;            wr = j[0]; pol = ~j[0];
        end else if (k < 7 * N) begin
            j = k - 5 * N; a = MAXA - j / 2;     wr = j[0]; pol = j[0];
        end else if (k < 9 * N) begin
            j = k - 7 * N; a = MAXA - j / 2;     wr = j[0]; pol = ~j[0];
        end else begin
            a = MAXA - (k - 9 * N); wr = 1'b0; pol = 1'b0;
        end
    endfunction

    logic [1:0]    cur_bg = 2'b00;
    int            mon_k = 0;
    logic [DW-1:0] mon_prev_wd = '0;
    logic          m_wr, m_pol;
    int            m_a;

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                if (mon_k < RUNC) begin
                    exp_op(mon_k, m_wr, m_a, m_pol);
                    chk($sformatf("mon k%0d write_read", mon_k), mem_if.write_read, m_wr);
                    chk($sformatf("mon k%0d address", mon_k), mem_if.address, m_a);
                    if (m_wr) begin
                        chk($sformatf("mon k%0d wdata", mon_k), mon_prev_wd,
                            pat(cur_bg, m_a) ^ {DW{m_pol}});
                    end
                end else begin
                    chk("mon drain write_read", mem_if.write_read, 0);
                    chk("mon drain address", mem_if.address, 0);
                    chk("mon drain wdata", mem_if.wdata, 0);
                end
                mon_k++;
            end else begin
                mon_k = 0;
                chk("mon idle write_read", mem_if.write_read, 0);
                chk("mon idle address", mem_if.address, 0);
                if (!start) chk("mon idle wdata", mem_if.wdata, 0);
            end
            chk("mon address range", mem_if.address <= MAXA, 1);
        end
        mon_prev_wd = mem_if.wdata;
    end

    task automatic run_test(input logic [1:0] bg, input int fault, input int restart_at,
                            output int n_busy, output int n_done, output int done_idx);
        cur_bg     = bg;
        fault_mode = fault;
        bg_sel     = bg;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_busy = 0; n_done = 0; done_idx = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("cleared fail on start", fail, 0);
                chk("cleared err_count on start", err_count, 0);
            end
            start = (i == restart_at);
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (done_idx < 0) done_idx = i;
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [1:0] bg;
        int         fault;
        logic       e_fail;
        logic [7:0] e_addr;
        logic [7:0] e_data;
        logic [2:0] e_elem;
        logic [7:0] e_err;
    } vec_t;

    vec_t vecs [8];
    int   nb, nd, di;

    initial begin
        vecs[0] = '{bg: 2'b00, fault: FNone,  e_fail: 0, e_addr: 0, e_data: 8'h00, e_elem: 0, e_err: 0};
        vecs[1] = '{bg: 2'b01, fault: FNone,  e_fail: 0, e_addr: 0, e_data: 8'h00, e_elem: 0, e_err: 0};
        vecs[2] = '{bg: 2'b10, fault: FNone,  e_fail: 0, e_addr: 0, e_data: 8'h00, e_elem: 0, e_err: 0};
        vecs[3] = '{bg: 2'b11, fault: FNone,  e_fail: 0, e_addr: 0, e_data: 8'h00, e_elem: 0, e_err: 0};
        vecs[4] = '{bg: 2'b00, fault: FStuck, e_fail: 1, e_addr: 5, e_data: 8'hF7, e_elem: 2, e_err: 2};
        vecs[5] = '{bg: 2'b01, fault: FStuck, e_fail: 1, e_addr: 5, e_data: 8'hA2, e_elem: 2, e_err: 2};
        vecs[6] = '{bg: 2'b10, fault: FCoup,  e_fail: 1, e_addr: 8, e_data: 8'hAA, e_elem: 5, e_err: 1};
        vecs[7] = '{bg: 2'b00, fault: FCoup,  e_fail: 1, e_addr: 8, e_data: 8'hFF, e_elem: 1, e_err: 4};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset fail", fail, 0);
        chk("reset err_count", err_count, 0);
        chk("reset write_read", mem_if.write_read, 0);
        chk("reset address", mem_if.address, 0);
        chk("reset wdata", mem_if.wdata, 0);
        @(posedge clk); #1 rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            run_test(vecs[v].bg, vecs[v].fault, -1, nb, nd, di);
            chk($sformatf("v%0d busy cycles", v), nb, 10 * N + 2);
            chk($sformatf("v%0d done pulses", v), nd, 1);
            chk($sformatf("v%0d done cycle", v), di, 10 * N + 2);
            chk($sformatf("v%0d fail", v), fail, vecs[v].e_fail);
            chk($sformatf("v%0d fail_addr", v), fail_addr, vecs[v].e_addr);
            chk($sformatf("v%0d fail_data", v), fail_data, vecs[v].e_data);
            chk($sformatf("v%0d fail_elem", v), fail_elem, vecs[v].e_elem);
            chk($sformatf("v%0d err_count", v), err_count, vecs[v].e_err);
        end

        // Second start pulse at RUN cycle 10 must be ignored
        run_test(2'b00, FNone, 10, nb, nd, di);
        chk("restart busy cycles", nb, 10 * N + 2);
        chk("restart done pulses", nd, 1);
        chk("restart done cycle", di, 10 * N + 2);
        chk("restart fail", fail, 0);

        // Reset at RUN cycle 40 of a failing run aborts it with no done pulse
        cur_bg = 2'b10; fault_mode = FStuck; bg_sel = 2'b10;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i <= 40; i++) @(negedge clk);
        chk("pre-reset busy", busy, 1);
        chk("pre-reset fail", fail, 1);
        chk("pre-reset err_count", err_count, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort fail", fail, 0);
        chk("abort fail_addr", fail_addr, 0);
        chk("abort fail_data", fail_data, 0);
        chk("abort fail_elem", fail_elem, 0);
        chk("abort err_count", err_count, 0);
        chk("abort write_read", mem_if.write_read, 0);
        chk("abort address", mem_if.address, 0);
        chk("abort wdata", mem_if.wdata, 0);
        nb = 0; nd = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) nd++;
        end
        chk("abort no busy", nb, 0);
        chk("abort no done", nd, 0);

        run_test(2'b00, FNone, -1, nb, nd, di);
        chk("rerun busy cycles", nb, 10 * N + 2);
        chk("rerun done pulses", nd, 1);
        chk("rerun done cycle", di, 10 * N + 2);
        chk("rerun fail", fail, 0);
        chk("rerun err_count", err_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
